sm_clk_gen: RTL and testbench

Parametrised multi-channel clock/strobe generator, successor to the single power-of-two tunable divider. Each channel divides the system clock by an arbitrary programmable integer and produces two outputs: a one-cycle `tick` strobe and a 50 % duty `clkOut` square wave. Each channel also offers single-step and externally gated modes driven by an asynchronous `step` pin. It sits at top level between the board clock and the CPU/peripheral clock-enable inputs.

---
 rtl/sm_clk_pkg.sv | 11 +
 rtl/sm_clk_channel.sv | 108 ++++++++++
 rtl/sm_clk_gen.sv | 36 +++
 tb/tb_sm_clk_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_clk_pkg.sv
// Shared mode encoding for the multi-channel clock/strobe generator.
package sm_clk_pkg;

   typedef enum logic [1:0] {
      SM_CLK_OFF   = 2'b00,
      SM_CLK_RUN   = 2'b01,
      SM_CLK_STEP  = 2'b10,
      SM_CLK_GATED = 2'b11
   } sm_clk_mode_t;

endpackage

// File: rtl/sm_clk_channel.sv
// One divider channel: step synchronizer, period counter and registered
// tick/clkOut outputs. The tick period is divide+1 enabled cycles.
module sm_clk_channel
   import sm_clk_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] divide,
   input  logic             step,
   output logic             tick,
   output logic             clkOut
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_prev;
   logic                   sync_out;
   logic                   step_rise;
   logic [WIDTH-1:0]       cnt;
   logic [WIDTH-1:0]       act_div;
   logic                   loaded;
   logic [WIDTH-1:0]       eff_div;
   sm_clk_mode_t           ch_mode;

   logic [WIDTH-1:0]       cnt_next;
   logic [WIDTH-1:0]       act_div_next;
   logic                   loaded_next;
   logic                   clk_next;
   logic                   tick_next;

   assign sync_out  = sync[SYNC_STAGES-1];
   assign step_rise = sync_out & ~sync_prev;
   assign eff_div   = loaded ? act_div : divide;
   assign ch_mode   = sm_clk_mode_t'(mode);

   // The synchronizer keeps sampling even when frozen, so a rise seen
   // while enable is low is consumed rather than replayed later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync      <= '0;
         sync_prev <= 1'b0;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], step};
         sync_prev <= sync_out;
      end
   end

   always_comb begin
      cnt_next     = cnt;
      act_div_next = act_div;
      loaded_next  = loaded;
      clk_next     = clkOut;
      tick_next    = 1'b0;
      if (enable) begin
         case (ch_mode)
            SM_CLK_OFF: begin
               cnt_next    = '0;
               loaded_next = 1'b0;
               clk_next    = 1'b0;
            end
            SM_CLK_STEP: begin
               cnt_next    = '0;
               loaded_next = 1'b0;
               tick_next   = step_rise;
               if (step_rise) clk_next = ~clkOut;
            end
            SM_CLK_RUN, SM_CLK_GATED: begin
               // Compare before increment, so the all-ones divisor never overflows.
               if (ch_mode == SM_CLK_RUN || sync_out) begin
                  loaded_next = 1'b1;
                  if (cnt == eff_div) begin
                     tick_next    = 1'b1;
                     cnt_next     = '0;
                     clk_next     = ~clkOut;
                     act_div_next = divide;
                  end else begin
                     cnt_next     = cnt + 1'b1;
                     act_div_next = eff_div;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         act_div <= '0;
         loaded  <= 1'b0;
         clkOut  <= 1'b0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         act_div <= act_div_next;
         loaded  <= loaded_next;
         clkOut  <= clk_next;
         tick    <= tick_next;
      end
   end

endmodule

// File: rtl/sm_clk_gen.sv
// Multi-channel clock/strobe generator: slices the flat control buses into
// fully independent sm_clk_channel instances.
module sm_clk_gen
   import sm_clk_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [WIDTH*CHANNELS-1:0] divide,
   input  logic [CHANNELS-1:0]       step,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       clkOut
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      sm_clk_channel #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .enable (enable),
         .mode   (mode[2*c +: 2]),
         .divide (divide[WIDTH*c +: WIDTH]),
         .step   (step[c]),
         .tick   (tick[c]),
         .clkOut (clkOut[c])
      );
   end

endmodule

// File: tb/tb_sm_clk_gen.sv
// Directed bench for sm_clk_gen: two 4-bit channels, two-stage step sync.
module tb_sm_clk_gen;
   import sm_clk_pkg::*;

   localparam int CHANNELS    = 2;
   localparam int WIDTH       = 4;
   localparam int SYNC_STAGES = 2;

   logic                      clk;
   logic                      rst;
   logic                      enable;
   logic [2*CHANNELS-1:0]     mode;
   logic [WIDTH*CHANNELS-1:0] divide;
   logic [CHANNELS-1:0]       step;
   logic [CHANNELS-1:0]       tick;
   logic [CHANNELS-1:0]       clkOut;

   int checks = 0;
   int passes = 0;

   sm_clk_gen #(
      .CHANNELS    (CHANNELS),
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .mode   (mode),
      .divide (divide),
      .step   (step),
      .tick   (tick),
      .clkOut (clkOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (tick !== 2'b00) $display("[TB] FAIL reset_tick: got %b, required 00", tick);
      else passes++;
      checks++;
      if (clkOut !== 2'b00) $display("[TB] FAIL reset_clkout: got %b, required 00", clkOut);
      else passes++;
      next_edge();
      rst = 1'b0;
      next_edge();
      checks++;
      if (tick !== 2'b00 || clkOut !== 2'b00)
         $display("[TB] FAIL off_idle: tick=%b clkOut=%b, required 00/00", tick, clkOut);
      else passes++;
   endtask

   task automatic test_run();
      divide[3:0] = 4'd3;
      mode[1:0]   = SM_CLK_RUN;
      for (int i = 1; i <= 16; i++) begin
         next_edge();
         checks++;
         if (tick[0] !== (i % 4 == 0))
            $display("[TB] FAIL run_tick edge %0d: got %b, required %b", i, tick[0], (i % 4 == 0));
         else passes++;
         checks++;
         if (clkOut[0] !== ((i / 4) % 2 == 1))
            $display("[TB] FAIL run_clkout edge %0d: got %b, required %b", i, clkOut[0], ((i / 4) % 2 == 1));
         else passes++;
         checks++;
         if (tick[1] !== 1'b0 || clkOut[1] !== 1'b0)
            $display("[TB] FAIL run_ch1_idle edge %0d: tick=%b clkOut=%b, required 0/0", i, tick[1], clkOut[1]);
         else passes++;
      end
   endtask

   task automatic test_div_change();
      next_edge();
      checks++;
      if (tick[0] !== 1'b0) $display("[TB] FAIL divchg_pre: got %b, required 0", tick[0]);
      else passes++;
      divide[3:0] = 4'd9;
      for (int k = 1; k <= 23; k++) begin
         next_edge();
         checks++;
         if (tick[0] !== (k == 3 || k == 13 || k == 23))
            $display("[TB] FAIL divchg_tick edge %0d: got %b, required %b", k, tick[0], (k == 3 || k == 13 || k == 23));
         else passes++;
         checks++;
         if (clkOut[0] !== ((k >= 3 && k < 13) || k >= 23))
            $display("[TB] FAIL divchg_clkout edge %0d: got %b, required %b", k, clkOut[0], ((k >= 3 && k < 13) || k >= 23));
         else passes++;
      end
   endtask

   task automatic test_zero_max();
      mode[1:0] = SM_CLK_OFF;
      next_edge();
      divide[3:0] = 4'd0;
      mode[1:0]   = SM_CLK_RUN;
      for (int i = 1; i <= 6; i++) begin
         next_edge();
         checks++;
         if (tick[0] !== 1'b1 || clkOut[0] !== (i % 2 == 1))
            $display("[TB] FAIL zero_div edge %0d: tick=%b clkOut=%b, required 1/%b", i, tick[0], clkOut[0], (i % 2 == 1));
         else passes++;
      end
      mode[1:0] = SM_CLK_OFF;
      next_edge();
      checks++;
      if (clkOut[0] !== 1'b0 || tick[0] !== 1'b0)
         $display("[TB] FAIL off_clear: tick=%b clkOut=%b, required 0/0", tick[0], clkOut[0]);
      else passes++;
      divide[3:0] = 4'd15;
      mode[1:0]   = SM_CLK_RUN;
      for (int i = 1; i <= 32; i++) begin
         next_edge();
         checks++;
         if (tick[0] !== (i % 16 == 0) || clkOut[0] !== ((i / 16) % 2 == 1))
            $display("[TB] FAIL max_div edge %0d: tick=%b clkOut=%b, required %b/%b",
                     i, tick[0], clkOut[0], (i % 16 == 0), ((i / 16) % 2 == 1));
         else passes++;
      end
   endtask

   task automatic test_step();
      mode = {SM_CLK_STEP, SM_CLK_OFF};
      next_edge();
      step[1] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         next_edge();
         checks++;
         if (tick[1] !== (i == 3) || clkOut[1] !== (i >= 3))
            $display("[TB] FAIL step1 edge %0d: tick=%b clkOut=%b, required %b/%b", i, tick[1], clkOut[1], (i == 3), (i >= 3));
         else passes++;
         if (i == 3) step[1] = 1'b0;
      end
      step[1] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         next_edge();
         checks++;
         if (tick[1] !== (j == 3) || clkOut[1] !== (j < 3))
            $display("[TB] FAIL step2 edge %0d: tick=%b clkOut=%b, required %b/%b", j, tick[1], clkOut[1], (j == 3), (j < 3));
         else passes++;
         if (j == 2) step[1] = 1'b0;
      end
      enable  = 1'b0;
      step[1] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         next_edge();
         checks++;
         if (tick[1] !== 1'b0 || clkOut[1] !== 1'b0)
            $display("[TB] FAIL step_lost edge %0d: tick=%b clkOut=%b, required 0/0", i, tick[1], clkOut[1]);
         else passes++;
         if (i == 3) step[1] = 1'b0;
      end
      enable = 1'b1;
      next_edge();
      checks++;
      if (tick[1] !== 1'b0) $display("[TB] FAIL step_no_replay: got %b, required 0", tick[1]);
      else passes++;
   endtask

   task automatic test_gated();
      mode = {SM_CLK_OFF, SM_CLK_OFF};
      step = '0;
      next_edge();
      divide[3:0] = 4'd4;
      mode[1:0]   = SM_CLK_GATED;
      step[0]     = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         next_edge();
         checks++;
         if (tick[0] !== (i == 12) || clkOut[0] !== (i >= 12))
            $display("[TB] FAIL gated edge %0d: tick=%b clkOut=%b, required %b/%b", i, tick[0], clkOut[0], (i == 12), (i >= 12));
         else passes++;
         if (i == 3) step[0] = 1'b0;
         if (i == 8) step[0] = 1'b1;
      end
   endtask

   task automatic test_enable_freeze();
      mode[1:0] = SM_CLK_OFF;
      step[0]   = 1'b0;
      next_edge();
      divide[3:0] = 4'd4;
      mode[1:0]   = SM_CLK_RUN;
      for (int i = 1; i <= 17; i++) begin
         next_edge();
         checks++;
         if (tick[0] !== (i == 12 || i == 17) || clkOut[0] !== (i >= 12 && i < 17))
            $display("[TB] FAIL freeze edge %0d: tick=%b clkOut=%b, required %b/%b",
                     i, tick[0], clkOut[0], (i == 12 || i == 17), (i >= 12 && i < 17));
         else passes++;
         if (i == 2) enable = 1'b0;
         if (i == 9) enable = 1'b1;
      end
   endtask

   task automatic test_async_reset();
      mode = {SM_CLK_OFF, SM_CLK_OFF};
      next_edge();
      divide = {4'd0, 4'd5};
      mode   = {SM_CLK_RUN, SM_CLK_RUN};
      for (int i = 1; i <= 9; i++) next_edge();
      checks++;
      if (clkOut[0] !== 1'b1 || tick[1] !== 1'b1)
         $display("[TB] FAIL areset_pre: clkOut0=%b tick1=%b, required 1/1", clkOut[0], tick[1]);
      else passes++;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (tick !== 2'b00 || clkOut !== 2'b00)
         $display("[TB] FAIL areset_immediate: tick=%b clkOut=%b, required 00/00", tick, clkOut);
      else passes++;
      next_edge();
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         next_edge();
         checks++;
         if (tick[0] !== (i == 6))
            $display("[TB] FAIL areset_ch0 edge %0d: got %b, required %b", i, tick[0], (i == 6));
         else passes++;
         checks++;
         if (tick[1] !== 1'b1 || clkOut[1] !== (i % 2 == 1))
            $display("[TB] FAIL areset_ch1 edge %0d: tick=%b clkOut=%b, required 1/%b", i, tick[1], clkOut[1], (i % 2 == 1));
         else passes++;
      end
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b1;
      mode   = '0;
      divide = '0;
      step   = '0;
      test_reset();
      test_run();
      test_div_change();
      test_zero_max();
      test_step();
      test_gated();
      test_enable_freeze();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
